// File: rtl/tnn_feature_loader.sv
// Streaming front end for the 2-bit-input TNN classifiers. It quantizes raw samples against three
// thresholds, packs NFEAT of them per frame and flags framing errors. Define TNN_LOADER_CNT_EN to add frame_cnt.
module tnn_feature_loader #(
  parameter int unsigned RAW_W = 8,
  parameter int unsigned NFEAT = 9,
  parameter int unsigned T1    = 64,
  parameter int unsigned T2    = 128,
  parameter int unsigned T3    = 192
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [RAW_W-1:0]     s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [2*NFEAT-1:0]   m_features,
  output logic                 err
`ifdef TNN_LOADER_CNT_EN
  ,
  output logic [15:0]          frame_cnt
`endif
);

  localparam int unsigned IdxW = (NFEAT > 1) ? $clog2(NFEAT) : 1;
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(NFEAT - 1);
  localparam logic [RAW_W-1:0] Thr1 = RAW_W'(T1);
  localparam logic [RAW_W-1:0] Thr2 = RAW_W'(T2);
  localparam logic [RAW_W-1:0] Thr3 = RAW_W'(T3);

  typedef enum logic [1:0] {StCollect, StHold, StDrain} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [2*NFEAT-1:0] shadow_q, shadow_d, shadow_wr;
  logic [2*NFEAT-1:0] feat_q, feat_d;
  logic               err_q, err_d;
  logic               beat;
  logic [1:0]         q;

  // Unsigned thresholds are ordered, so the highest one crossed wins.
  function automatic logic [1:0] quantize(input logic [RAW_W-1:0] x);
    logic [1:0] r;
    r = 2'd0;
    if (x >= Thr1) r = 2'd1;
    if (x >= Thr2) r = 2'd2;
    if (x >= Thr3) r = 2'd3;
    return r;
  endfunction

  assign beat = s_valid && s_ready;
  assign q    = quantize(s_data);

  always_comb begin
    shadow_wr = shadow_q;
    for (int k = 0; k < int'(NFEAT); k++) begin
      if (idx_q == IdxW'(k)) shadow_wr[2*k +: 2] = q;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StCollect;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    feat_d   = feat_q;
    err_d    = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (beat) begin
          shadow_d = shadow_wr;
          if (idx_q == LastIdx) begin
            idx_d = '0;
            if (s_last) begin
              feat_d  = shadow_wr;
              state_d = StHold;
            end else begin
              err_d   = 1'b1;
              state_d = StDrain;
            end
          end else if (s_last) begin
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StHold: begin
        if (m_ready) state_d = StCollect;
      end
      StDrain: begin
        if (beat && s_last) begin
          idx_d   = '0;
          state_d = StCollect;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = StCollect;
      end
    endcase
  end

  // Outputs decode from the state register only, so s_ready never follows m_ready.
  always_comb begin
    s_ready = 1'b1;
    m_valid = 1'b0;
    unique case (state_q)
      StCollect: s_ready = 1'b1;
      StHold: begin
        s_ready = 1'b0;
        m_valid = 1'b1;
      end
      StDrain:   s_ready = 1'b1;
      default:   s_ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      shadow_q <= '0;
      feat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      feat_q   <= feat_d;
      err_q    <= err_d;
    end
  end

  assign m_features = feat_q;
  assign err        = err_q;

`ifdef TNN_LOADER_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (m_valid && m_ready) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign frame_cnt = cnt_q;
`endif

endmodule

// File: doc/tnn_feature_loader.md
# tnn_feature_loader

Streaming front end for the 2-bit-input TNN classifier cores. It accepts raw unsigned feature samples one per beat over a valid/ready stream and quantizes each to 2 bits against three fixed thresholds. It assembles nine quantized features into one packed vector and presents it, registered, to the classifier's `input_a`…`input_i` ports with a valid/ready handshake. It is the producer side of the classifier's feature interface and also flags framing errors on the input stream.

## Interface
- `RAW_W`, default 8: width of a raw feature sample.
- `NFEAT`, default 9: features per vector; feature k drives classifier input letter k (0 → `input_a`).
- `T1`, default 64: first quantization threshold.
- `T2`, default 128: second threshold; `T1 < T2 < T3` is required.
- `T3`, default 192: third threshold.

- `clk`  in  1  clock. Everything is sampled on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `s_valid`  in  1  raw sample valid.
- `s_ready`  out  1  loader accepts a sample this cycle.
- `s_data`  in  RAW_W  raw unsigned sample.
- `s_last`  in  1  marks the final sample of a vector.
- `m_valid`  out  1  packed vector valid.
- `m_ready`  in  1  classifier side takes the vector.
- `m_features`  out  2*NFEAT  packed vector; feature k sits at bits [2k+1:2k].
- `err`  out  1  one-cycle pulse on a framing error.
- `frame_cnt`  out  16  emitted-vector count. Present only when `TNN_LOADER_CNT_EN` is defined.

## Operation
- **Beat and quantization.** A beat is accepted when `s_valid && s_ready`. Each accepted sample x maps to q:
  - q = 0 if x < T1
  - q = 1 if T1 ≤ x < T2
  - q = 2 if T2 ≤ x < T3
  - q = 3 if x ≥ T3
  - All comparisons are unsigned and RAW_W wide.
- **State machine.** States are COLLECT, HOLD and DRAIN, with an index register idx of width ceil(log2(NFEAT)).
- **COLLECT.** `s_ready`=1. Each accepted beat writes q into the slot idx of the shadow vector.
  - idx < NFEAT-1 with `s_last`=0: idx increments.
  - idx < NFEAT-1 with `s_last`=1 (short frame): the partial vector is discarded, idx goes to 0, `err` pulses, and the FSM stays in COLLECT.
  - idx = NFEAT-1 with `s_last`=1: the complete shadow vector loads into `m_features`, idx goes to 0, and the FSM goes to HOLD.
  - idx = NFEAT-1 with `s_last`=0 (long frame): the vector is discarded, `err` pulses, idx goes to 0, and the FSM goes to DRAIN.
- **HOLD.** `m_valid`=1 and `s_ready`=0. `m_features` stays stable until `m_valid && m_ready`, then the FSM returns to COLLECT.
- **DRAIN.** `s_ready`=1. Accepted beats are discarded. The beat with `s_last`=1 returns the FSM to COLLECT with idx = 0. No further `err` pulses are produced while in DRAIN.
- **Stability.** `m_features` changes only on the COLLECT→HOLD transition. Unused shadow slots are never visible, because a vector is emitted only when full.

## Timing
- **Reset values.**
  - FSM in COLLECT, idx = 0.
  - `s_ready`=1 from the first cycle after reset release.
  - `m_valid`=0, `m_features`=0, `err`=0, `frame_cnt`=0.
- **Mid-frame reset.** A reset in the middle of a frame discards the partial vector. Reset during HOLD drops the pending vector.
- **Latency.** The last beat is accepted at edge n; `m_valid` is high in the cycle after edge n.
- **Throughput.** Minimum 10 cycles per vector: 9 beats plus 1 HOLD cycle with `m_ready`=1. `s_ready` returns high in the cycle after the output handshake.
- **Backpressure.** `s_ready` depends only on the state (registered), never combinationally on `m_ready`.
- **Error timing.** `err` is registered and high for exactly the one cycle after the offending beat.
- **Handshakes.** Upstream must hold `s_data`/`s_last` stable while `s_valid`=1 and `s_ready`=0. Once `m_valid` is high it stays high until the handshake completes.

## Configuration
- `TNN_LOADER_CNT_EN` defined:
  - `frame_cnt` port and register are present.
  - The count increments by 1 on each `m_valid && m_ready` and wraps from 0xFFFF to 0.
  - Error frames are not counted.
- `TNN_LOADER_CNT_EN` undefined:
  - The port and register are absent.
  - All other behaviour is identical.

## Test plan
- **Reset.** Assert `rst` mid-frame after 4 beats, then send a clean 9-beat frame → no output for the partial frame; the clean frame is emitted correctly.
- **Quantization boundaries.** Send samples 0, 63, 64, 127, 128, 191, 192, 255, 100 with `s_last` on the 9th → `m_features` = {2'd1,2'd3,2'd3,2'd2,2'd2,2'd1,2'd1,2'd0,2'd0} (MSB = feature 8). `m_valid` rises one cycle after the 9th beat.
- **Backpressure.** Hold `m_ready`=0 for 20 cycles → `m_valid` and `m_features` are stable and `s_ready`=0 throughout. Raise `m_ready` → handshake completes, and `s_ready`=1 the next cycle.
- **Short frame.** Send `s_last` on the 5th beat → one `err` pulse, no `m_valid`. The following good frame is emitted intact.
- **Long frame.** Send 12 beats with `s_last` only on the 12th → one `err` pulse after beat 9, beats 10–12 are drained, no `m_valid`. The next frame is correct.
- **Counter** (`TNN_LOADER_CNT_EN`). Send 3 good frames and 1 error frame → `frame_cnt` = 3. Force the count to 0xFFFF via back-to-back frames → the next handshake wraps it to 0.
